calc_entry_sequencer: RTL and testbench

- Keypad-driven FSM that sequences one calculator operation: operand A entry, operator select, operand B entry, ALU start/done handshake, result display.
- Owns the operand registers and the 2-bit display-select `state`.
- `state`, A, B and the result feed the binary-to-digit display block; `alu_start`/`op` drive the arithmetic unit.

---
 rtl/calc_entry_sequencer_if.sv | 26 ++
 rtl/calc_entry_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_calc_entry_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/calc_entry_sequencer_if.sv
// Keypad/ALU/display bundle for the calculator entry sequencer.
// The master side drives keys and ALU responses; the sequencer is the slave.
interface calc_entry_sequencer_if;
  logic               key_valid;
  logic [4:0]         key_code;
  logic signed [15:0] alu_result;
  logic               alu_flag;
  logic               alu_done;
  logic signed [15:0] A;
  logic signed [15:0] B;
  logic [1:0]         op;
  logic               alu_start;
  logic [1:0]         state;
  logic signed [15:0] data_out;
  logic               err;

  modport master (
    output key_valid, key_code, alu_result, alu_flag, alu_done,
    input  A, B, op, alu_start, state, data_out, err
  );

  modport slave (
    input  key_valid, key_code, alu_result, alu_flag, alu_done,
    output A, B, op, alu_start, state, data_out, err
  );
endinterface

// File: rtl/calc_entry_sequencer.sv
// Calculator entry FSM: operand A, operator, operand B, ALU handshake, result view.
// Operands are kept as magnitude plus sign and presented in two's complement.
module calc_entry_sequencer #(
  parameter int MAX_DIGITS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  calc_entry_sequencer_if.slave bus
);

  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [DCNT_W-1:0] MAXD      = DCNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]  TOUT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_A, S_OP, S_B, S_WAIT, S_RES} state_t;

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [13:0]         r_a_mag, w_a_mag_nx, r_b_mag, w_b_mag_nx;
  logic                r_a_neg, w_a_neg_nx, r_b_neg, w_b_neg_nx;
  logic [DCNT_W-1:0]   r_a_cnt, w_a_cnt_nx, r_b_cnt, w_b_cnt_nx;
  logic [1:0]          r_op, w_op_nx;
  logic                r_start, w_start_nx;
  logic signed [15:0]  r_data, w_data_nx;
  logic                r_err, w_err_nx;
  logic [1:0]          w_disp;

  logic       w_is_digit, w_is_op, w_is_eq, w_is_clr, w_is_neg;
  logic [3:0] w_digit;
  logic [4:0] w_op_full;
  logic [1:0] w_op_code;

  function automatic logic [13:0] push_digit(input logic [13:0] mag, input logic [3:0] d);
    return 14'(18'(mag) * 18'd10 + 18'(d));
  endfunction

  function automatic logic signed [15:0] to_signed(input logic [13:0] mag, input logic neg);
    logic signed [15:0] v;
    v = signed'({2'b00, mag});
    return neg ? -v : v;
  endfunction

  function automatic logic [13:0] abs_mag(input logic signed [15:0] v);
    return 14'((v < 0) ? -v : v);
  endfunction

  function automatic logic in_range(input logic signed [15:0] v);
    return (v >= -16'sd9999) && (v <= 16'sd9999);
  endfunction

  assign w_is_digit = bus.key_valid && (bus.key_code <= 5'd9);
  assign w_is_op    = bus.key_valid && (bus.key_code >= 5'd10) && (bus.key_code <= 5'd13);
  assign w_is_eq    = bus.key_valid && (bus.key_code == 5'd14);
  assign w_is_clr   = bus.key_valid && (bus.key_code == 5'd15);
  assign w_is_neg   = bus.key_valid && (bus.key_code == 5'd16);
  assign w_digit    = bus.key_code[3:0];
  assign w_op_full  = bus.key_code - 5'd10;
  assign w_op_code  = w_op_full[1:0];

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_a_mag_nx = r_a_mag;
    w_a_neg_nx = r_a_neg;
    w_a_cnt_nx = r_a_cnt;
    w_b_mag_nx = r_b_mag;
    w_b_neg_nx = r_b_neg;
    w_b_cnt_nx = r_b_cnt;
    w_op_nx    = r_op;
    w_start_nx = 1'b0;
    w_data_nx  = r_data;
    w_err_nx   = r_err;

    if (w_is_clr) begin
      w_state_nx = S_A;
      w_cnt_nx   = '0;
      w_a_mag_nx = '0;
      w_a_neg_nx = 1'b0;
      w_a_cnt_nx = '0;
      w_b_mag_nx = '0;
      w_b_neg_nx = 1'b0;
      w_b_cnt_nx = '0;
      w_op_nx    = 2'b00;
      w_data_nx  = '0;
      w_err_nx   = 1'b0;
    end else begin
      case (r_state)
        S_A: begin
          // Leading zeros leave the magnitude at 0 and do not use up a digit slot
          if (w_is_digit) begin
            if (r_a_cnt < MAXD) begin
              w_a_mag_nx = push_digit(r_a_mag, w_digit);
              if (r_a_mag != 14'd0 || w_digit != 4'd0) w_a_cnt_nx = r_a_cnt + 1'b1;
            end
          end else if (w_is_neg) begin
            w_a_neg_nx = ~r_a_neg;
          end else if (w_is_op) begin
            w_op_nx    = w_op_code;
            w_state_nx = S_OP;
          end
        end
        S_OP: begin
          if (w_is_op) begin
            w_op_nx = w_op_code;
          end else if (w_is_digit) begin
            w_b_mag_nx = 14'(w_digit);
            w_b_neg_nx = 1'b0;
            w_b_cnt_nx = (w_digit != 4'd0) ? DCNT_W'(1) : '0;
            w_state_nx = S_B;
          end
        end
        S_B: begin
          if (w_is_digit) begin
            if (r_b_cnt < MAXD) begin
              w_b_mag_nx = push_digit(r_b_mag, w_digit);
              if (r_b_mag != 14'd0 || w_digit != 4'd0) w_b_cnt_nx = r_b_cnt + 1'b1;
            end
          end else if (w_is_neg) begin
            w_b_neg_nx = ~r_b_neg;
          end else if (w_is_eq) begin
            w_start_nx = 1'b1;
            w_cnt_nx   = '0;
            w_state_nx = S_WAIT;
          end
        end
        S_WAIT: begin
          // A completion on the last timeout cycle still delivers its result
          if (bus.alu_done) begin
            w_data_nx  = bus.alu_result;
            w_err_nx   = bus.alu_flag;
            w_state_nx = S_RES;
          end else if (r_cnt == TOUT_LAST) begin
            w_err_nx   = 1'b1;
            w_state_nx = S_RES;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        S_RES: begin
          if (w_is_digit) begin
            w_a_mag_nx = 14'(w_digit);
            w_a_neg_nx = 1'b0;
            w_a_cnt_nx = (w_digit != 4'd0) ? DCNT_W'(1) : '0;
            w_b_mag_nx = '0;
            w_b_neg_nx = 1'b0;
            w_b_cnt_nx = '0;
            w_err_nx   = 1'b0;
            w_state_nx = S_A;
          end else if (w_is_op && !r_err && in_range(r_data)) begin
            w_a_mag_nx = abs_mag(r_data);
            w_a_neg_nx = (r_data < 0);
            w_a_cnt_nx = MAXD;
            w_b_mag_nx = '0;
            w_b_neg_nx = 1'b0;
            w_b_cnt_nx = '0;
            w_op_nx    = w_op_code;
            w_state_nx = S_OP;
          end
        end
        default: w_state_nx = S_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_A;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_a_mag <= '0;
      r_a_neg <= 1'b0;
      r_a_cnt <= '0;
      r_b_mag <= '0;
      r_b_neg <= 1'b0;
      r_b_cnt <= '0;
      r_op    <= 2'b00;
      r_start <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_a_mag <= w_a_mag_nx;
      r_a_neg <= w_a_neg_nx;
      r_a_cnt <= w_a_cnt_nx;
      r_b_mag <= w_b_mag_nx;
      r_b_neg <= w_b_neg_nx;
      r_b_cnt <= w_b_cnt_nx;
      r_op    <= w_op_nx;
      r_start <= w_start_nx;
      r_data  <= w_data_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_disp = 2'b00;
    case (r_state)
      S_OP:         w_disp = 2'b01;
      S_B, S_WAIT:  w_disp = 2'b10;
      S_RES:        w_disp = 2'b11;
      default:      w_disp = 2'b00;
    endcase
  end

  assign bus.A         = to_signed(r_a_mag, r_a_neg);
  assign bus.B         = to_signed(r_b_mag, r_b_neg);
  assign bus.op        = r_op;
  assign bus.alu_start = r_start;
  assign bus.state     = w_disp;
  assign bus.data_out  = r_data;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Directed bench for calc_entry_sequencer: keypad sequences with hand-computed results.
module tb_calc_entry_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   n_start;

  calc_entry_sequencer_if u_if ();

  calc_entry_sequencer #(.MAX_DIGITS(4), .TIMEOUT(255)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && u_if.alu_start) n_start++;

  task automatic expect_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] code);
    @(negedge clk);
    u_if.key_valid = 1'b1;
    u_if.key_code  = code;
    @(negedge clk);
    u_if.key_valid = 1'b0;
  endtask

  task automatic reply(input int res, input logic flag);
    @(negedge clk);
    u_if.alu_done   = 1'b1;
    u_if.alu_result = 16'(res);
    u_if.alu_flag   = flag;
    @(negedge clk);
    u_if.alu_done = 1'b0;
    u_if.alu_flag = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_start = 0;
    reset = 1'b1;
    u_if.key_valid = 1'b0; u_if.key_code = '0;
    u_if.alu_result = '0; u_if.alu_flag = 1'b0; u_if.alu_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    expect_eq("rst_A", u_if.A, 0);
    expect_eq("rst_B", u_if.B, 0);
    expect_eq("rst_op", u_if.op, 0);
    expect_eq("rst_state", u_if.state, 0);
    expect_eq("rst_data", u_if.data_out, 0);
    expect_eq("rst_err", u_if.err, 0);
    expect_eq("rst_start", u_if.alu_start, 0);

    // Digit limit and leading zeros
    press(1); press(2); press(3); press(4); press(5);
    expect_eq("A_limit", u_if.A, 1234);
    expect_eq("A_limit_state", u_if.state, 0);
    press(15); press(0); press(0); press(1); press(2); press(3); press(4); press(9);
    expect_eq("A_lead0", u_if.A, 1234);

    // -7 + 3 = -4
    press(15); press(7); press(16);
    expect_eq("A_neg", u_if.A, -7);
    press(10);
    expect_eq("op_state", u_if.state, 1);
    expect_eq("op_add", u_if.op, 0);
    press(3);
    expect_eq("B_3", u_if.B, 3);
    expect_eq("B_state", u_if.state, 2);
    press(14);
    expect_eq("start_hi", u_if.alu_start, 1);
    expect_eq("wait_state", u_if.state, 2);
    @(negedge clk);
    expect_eq("start_lo", u_if.alu_start, 0);
    repeat (2) @(negedge clk);
    reply(-4, 1'b0);
    expect_eq("res_data", u_if.data_out, -4);
    expect_eq("res_state", u_if.state, 3);
    expect_eq("res_err", u_if.err, 0);

    // 9 / 0 with ALU error, op ignored, digit restarts
    press(9);
    expect_eq("restart_A", u_if.A, 9);
    press(13); press(0); press(14);
    reply(0, 1'b1);
    expect_eq("div0_err", u_if.err, 1);
    expect_eq("div0_state", u_if.state, 3);
    press(10);
    expect_eq("errop_state", u_if.state, 3);
    expect_eq("errop_op", u_if.op, 3);
    press(5);
    expect_eq("d5_A", u_if.A, 5);
    expect_eq("d5_B", u_if.B, 0);
    expect_eq("d5_err", u_if.err, 0);
    expect_eq("d5_state", u_if.state, 0);

    // Timeout with a key injected mid-wait
    press(10); press(1); press(14);
    for (int i = 0; i < 254; i++) begin
      u_if.key_valid = (i == 10);
      u_if.key_code  = 5'd7;
      @(negedge clk);
    end
    u_if.key_valid = 1'b0;
    expect_eq("to_still_wait", u_if.state, 2);
    expect_eq("to_key_ign", u_if.B, 1);
    @(negedge clk);
    expect_eq("to_state", u_if.state, 3);
    expect_eq("to_err", u_if.err, 1);
    expect_eq("to_data", u_if.data_out, 0);
    repeat (9) @(negedge clk);
    reply(77, 1'b0);
    expect_eq("late_data", u_if.data_out, 0);
    expect_eq("late_state", u_if.state, 3);
    expect_eq("late_err", u_if.err, 1);

    // Chaining from result 42
    press(4); press(10); press(2); press(14);
    reply(42, 1'b0);
    expect_eq("r42", u_if.data_out, 42);
    press(12);
    expect_eq("chain_A", u_if.A, 42);
    expect_eq("chain_op", u_if.op, 2);
    expect_eq("chain_state", u_if.state, 1);
    expect_eq("chain_B0", u_if.B, 0);
    press(2);
    expect_eq("chain_B", u_if.B, 2);
    expect_eq("chain_Bst", u_if.state, 2);

    // Out-of-range result blocks chaining; -9999 is accepted
    press(14);
    reply(12000, 1'b0);
    press(11);
    expect_eq("oor_state", u_if.state, 3);
    expect_eq("oor_A", u_if.A, 42);
    press(1); press(10); press(1); press(14);
    reply(-9999, 1'b0);
    press(11);
    expect_eq("min_A", u_if.A, -9999);
    expect_eq("min_op", u_if.op, 1);
    expect_eq("min_state", u_if.state, 1);

    // Clear coinciding with alu_done
    press(3); press(14);
    @(negedge clk);
    u_if.key_valid = 1'b1; u_if.key_code = 5'd15;
    u_if.alu_done = 1'b1; u_if.alu_result = 16'sd99;
    @(negedge clk);
    u_if.key_valid = 1'b0; u_if.alu_done = 1'b0;
    expect_eq("clr_A", u_if.A, 0);
    expect_eq("clr_B", u_if.B, 0);
    expect_eq("clr_op", u_if.op, 0);
    expect_eq("clr_state", u_if.state, 0);
    expect_eq("clr_data", u_if.data_out, 0);
    expect_eq("clr_err", u_if.err, 0);
    reply(55, 1'b0);
    expect_eq("idle_done_data", u_if.data_out, 0);
    expect_eq("idle_done_state", u_if.state, 0);

    // Reset in the middle of WAIT
    press(3); press(10); press(4); press(14);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    reply(88, 1'b1);
    expect_eq("rw_state", u_if.state, 0);
    expect_eq("rw_data", u_if.data_out, 0);
    expect_eq("rw_err", u_if.err, 0);
    expect_eq("rw_A", u_if.A, 0);
    expect_eq("rw_start", u_if.alu_start, 0);
    expect_eq("start_count", n_start, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
